// File: rtl/reg_file_pkg.sv
// Shared definitions for the GPR file: bus widths, register count and the
// enable/zero constants used by the ID and WB stages.
package reg_file_pkg;

  localparam int unsigned DATA_BUS_WIDTH = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned PEND_BUS_WIDTH = 2;
  localparam int unsigned REG_NUM        = 32;

  localparam logic [DATA_BUS_WIDTH-1:0] ZERO_WORD     = '0;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG_ADDR = '0;

  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bundle: two ID read ports, the WB write port, the ID
// destination reservation and the scoreboard error flag.
//   master: ID/WB side (drives enables, addresses, write data)
//   slave : register file (drives read data, busy flags, pend_err)
interface reg_file_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  read_en_1;
  logic [ADDR_WIDTH-1:0] read_addr_1;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic                  read_busy_1;
  logic                  read_en_2;
  logic [ADDR_WIDTH-1:0] read_addr_2;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic                  read_busy_2;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  reserve_en;
  logic [ADDR_WIDTH-1:0] reserve_addr;
  logic                  pend_err;

  modport master (
    output read_en_1, read_addr_1, read_en_2, read_addr_2,
    output write_en, write_addr, write_data, reserve_en, reserve_addr,
    input  read_data_1, read_busy_1, read_data_2, read_busy_2, pend_err
  );

  modport slave (
    input  read_en_1, read_addr_1, read_en_2, read_addr_2,
    input  write_en, write_addr, write_data, reserve_en, reserve_addr,
    output read_data_1, read_busy_1, read_data_2, read_busy_2, pend_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one saturating counter per register, incremented
// by ID reservations and decremented by WB write-backs, plus per-port busy
// lookup and a sticky over/underflow flag.
// Ports: clk, rst (sync, active-high); reserve_en/addr; write_en/addr;
//        read_en/addr for two ports; read_busy_1/2 and pend_err outputs.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int unsigned PEND_WIDTH = PEND_BUS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reserve_en,
  input  logic [ADDR_WIDTH-1:0] reserve_addr,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  read_en_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  input  logic                  read_en_2,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic                  read_busy_1,
  output logic                  read_busy_2,
  output logic                  pend_err
);

  localparam int unsigned              RegCount = 2 ** ADDR_WIDTH;
  localparam logic [PEND_WIDTH-1:0]    PendMax  = '1;
  localparam logic [PEND_WIDTH-1:0]    PendOne  = PEND_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]    AddrZero = ADDR_WIDTH'(ZERO_REG_ADDR);

  logic [PEND_WIDTH-1:0] pend_q [RegCount];
  logic [PEND_WIDTH-1:0] pend_d [RegCount];
  logic                  err_q, err_d;

  always_comb begin
    logic inc, dec;
    inc    = 1'b0;
    dec    = 1'b0;
    pend_d = pend_q;
    err_d  = err_q;
    for (int unsigned r = 1; r < RegCount; r++) begin
      inc = (reserve_en == WRITE_ENABLE) && (reserve_addr == ADDR_WIDTH'(r));
      dec = (write_en == WRITE_ENABLE) && (write_addr == ADDR_WIDTH'(r));
      // Reserve and release of the same register cancel out.
      if (inc && !dec) begin
        if (pend_q[r] == PendMax) err_d = 1'b1;
        else                      pend_d[r] = pend_q[r] + PendOne;
      end else if (dec && !inc) begin
        if (pend_q[r] == '0) err_d = 1'b1;
        else                 pend_d[r] = pend_q[r] - PendOne;
      end
    end
    pend_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '{default: '0};
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  // A release that drains the last pending write clears busy this cycle:
  // the write-data bypass already hands the value to the reader.
  function automatic logic busy_of(logic en, logic [ADDR_WIDTH-1:0] addr,
                                   logic [PEND_WIDTH-1:0] pend);
    if (rst || en == READ_DISABLE || addr == AddrZero) return 1'b0;
    if (pend == '0) return 1'b0;
    if (write_en == WRITE_ENABLE && write_addr == addr && pend == PendOne) return 1'b0;
    return 1'b1;
  endfunction

  always_comb begin
    read_busy_1 = busy_of(read_en_1, read_addr_1, pend_q[read_addr_1]);
    read_busy_2 = busy_of(read_en_2, read_addr_2, pend_q[read_addr_2]);
  end

  assign pend_err = err_q;

endmodule

// File: rtl/reg_file.sv
// MIPS GPR file: 2**ADDR_WIDTH registers with $0 hardwired to zero, two
// combinational read ports with write-to-read bypass, one WB write port and
// a pending-write scoreboard for the ID stall logic.
// Ports: clk, rst (sync, active-high), bus (reg_file_if.slave).
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_BUS_WIDTH,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int unsigned PEND_WIDTH = PEND_BUS_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  reg_file_if.slave bus
);

  localparam int unsigned           RegCount = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] AddrZero = ADDR_WIDTH'(ZERO_REG_ADDR);
  localparam logic [DATA_WIDTH-1:0] WordZero = DATA_WIDTH'(ZERO_WORD);

  logic [DATA_WIDTH-1:0] regs_q [RegCount];

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else if (bus.write_en == WRITE_ENABLE && bus.write_addr != AddrZero) begin
      regs_q[bus.write_addr] <= bus.write_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(logic en, logic [ADDR_WIDTH-1:0] addr,
                                                      logic [DATA_WIDTH-1:0] stored);
    if (rst || en == READ_DISABLE || addr == AddrZero) return WordZero;
    if (bus.write_en == WRITE_ENABLE && bus.write_addr == addr) return bus.write_data;
    return stored;
  endfunction

  always_comb begin
    bus.read_data_1 = read_port(bus.read_en_1, bus.read_addr_1, regs_q[bus.read_addr_1]);
    bus.read_data_2 = read_port(bus.read_en_2, bus.read_addr_2, regs_q[bus.read_addr_2]);
  end

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PEND_WIDTH (PEND_WIDTH)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .reserve_en   (bus.reserve_en),
    .reserve_addr (bus.reserve_addr),
    .write_en     (bus.write_en),
    .write_addr   (bus.write_addr),
    .read_en_1    (bus.read_en_1),
    .read_addr_1  (bus.read_addr_1),
    .read_en_2    (bus.read_en_2),
    .read_addr_2  (bus.read_addr_2),
    .read_busy_1  (bus.read_busy_1),
    .read_busy_2  (bus.read_busy_2),
    .pend_err     (bus.pend_err)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed plus random bench for reg_file against a simple array/counter model.
module tb_reg_file;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  reg_file #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .PEND_WIDTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: register values, integer pending counts, sticky error.
  logic [31:0] m_regs [32];
  int          m_pend [32];
  bit          m_err;

  function automatic logic [31:0] exp_data(logic en, logic [4:0] a);
    if (rst || !en || a == 0) return 32'h0;
    if (bus.write_en && bus.write_addr == a) return bus.write_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(logic en, logic [4:0] a);
    if (rst || !en || a == 0) return 1'b0;
    if (m_pend[a] == 0) return 1'b0;
    if (bus.write_en && bus.write_addr == a && m_pend[a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst              = 1'b0;
    bus.read_en_1    = 1'b0; bus.read_addr_1 = '0;
    bus.read_en_2    = 1'b0; bus.read_addr_2 = '0;
    bus.write_en     = 1'b0; bus.write_addr  = '0; bus.write_data = '0;
    bus.reserve_en   = 1'b0; bus.reserve_addr = '0;
  endtask

  // Mid-cycle: compare every output against the model.
  task automatic settle();
    @(negedge clk);
    #1;
    check("model_data1", bus.read_data_1, exp_data(bus.read_en_1, bus.read_addr_1));
    check("model_data2", bus.read_data_2, exp_data(bus.read_en_2, bus.read_addr_2));
    check("model_busy1", 32'(bus.read_busy_1), 32'(exp_busy(bus.read_en_1, bus.read_addr_1)));
    check("model_busy2", 32'(bus.read_busy_2), 32'(exp_busy(bus.read_en_2, bus.read_addr_2)));
    check("model_err", 32'(bus.pend_err), 32'(m_err));
  endtask

  // Rising edge, then advance the model with the inputs that were applied.
  task automatic tick();
    bit inc, dec;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 0;
      end
      m_err = 1'b0;
    end else begin
      if (bus.write_en && bus.write_addr != 0) m_regs[bus.write_addr] = bus.write_data;
      inc = bus.reserve_en && bus.reserve_addr != 0;
      dec = bus.write_en && bus.write_addr != 0;
      if (inc && dec && bus.reserve_addr == bus.write_addr) begin
        inc = 1'b0;
        dec = 1'b0;
      end
      if (inc) begin
        if (m_pend[bus.reserve_addr] == 3) m_err = 1'b1;
        else m_pend[bus.reserve_addr]++;
      end
      if (dec) begin
        if (m_pend[bus.write_addr] == 0) m_err = 1'b1;
        else m_pend[bus.write_addr]--;
      end
    end
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end
    m_err = 1'b0;
    idle();
    do_reset();

    // Reset clears written data and the error flag.
    idle(); bus.write_en = 1; bus.write_addr = 5; bus.write_data = 32'h1234; step();
    do_reset();
    idle(); bus.read_en_1 = 1; bus.read_addr_1 = 5; settle();
    check("rst_data", bus.read_data_1, 32'h0);
    check("rst_busy", 32'(bus.read_busy_1), 32'h0);
    check("rst_err", 32'(bus.pend_err), 32'h0);
    tick();

    // Basic write/read and the zero register.
    idle(); bus.write_en = 1; bus.write_addr = 3; bus.write_data = 32'hDEADBEEF; step();
    idle(); bus.read_en_1 = 1; bus.read_addr_1 = 3; settle();
    check("basic_r3", bus.read_data_1, 32'hDEADBEEF);
    tick();
    idle(); bus.write_en = 1; bus.write_addr = 0; bus.write_data = 32'hFFFFFFFF;
    bus.read_en_1 = 1; bus.read_addr_1 = 0; settle();
    check("r0_same_cycle", bus.read_data_1, 32'h0);
    tick();
    idle(); bus.read_en_1 = 1; bus.read_addr_1 = 0; bus.read_en_2 = 0; bus.read_addr_2 = 3;
    settle();
    check("r0_after", bus.read_data_1, 32'h0);
    check("en2_off", bus.read_data_2, 32'h0);
    tick();

    // Bypass on both ports.
    idle(); bus.write_en = 1; bus.write_addr = 7; bus.write_data = 32'h11111111; step();
    idle(); bus.write_en = 1; bus.write_addr = 7; bus.write_data = 32'hA5A5A5A5;
    bus.read_en_1 = 1; bus.read_addr_1 = 7; bus.read_en_2 = 1; bus.read_addr_2 = 7; settle();
    check("bypass_p1", bus.read_data_1, 32'hA5A5A5A5);
    check("bypass_p2", bus.read_data_2, 32'hA5A5A5A5);
    tick();

    // Scoreboard sequence on r9.
    do_reset();
    idle(); bus.reserve_en = 1; bus.reserve_addr = 9; step();
    idle(); bus.read_en_1 = 1; bus.read_addr_1 = 9; settle();
    check("r9_busy_1", 32'(bus.read_busy_1), 32'h1);
    tick();
    idle(); bus.reserve_en = 1; bus.reserve_addr = 9; step();
    idle(); bus.write_en = 1; bus.write_addr = 9; bus.write_data = 32'h1; step();
    idle(); bus.read_en_1 = 1; bus.read_addr_1 = 9; settle();
    check("r9_busy_still", 32'(bus.read_busy_1), 32'h1);
    tick();
    idle(); bus.write_en = 1; bus.write_addr = 9; bus.write_data = 32'h2;
    bus.read_en_1 = 1; bus.read_addr_1 = 9; settle();
    check("r9_release_busy", 32'(bus.read_busy_1), 32'h0);
    check("r9_release_data", bus.read_data_1, 32'h2);
    tick();

    // Simultaneous reserve and release of r4 with one pending.
    idle(); bus.reserve_en = 1; bus.reserve_addr = 4; step();
    idle(); bus.reserve_en = 1; bus.reserve_addr = 4;
    bus.write_en = 1; bus.write_addr = 4; bus.write_data = 32'h44; step();
    idle(); bus.read_en_2 = 1; bus.read_addr_2 = 4; settle();
    check("r4_busy", 32'(bus.read_busy_2), 32'h1);
    check("r4_no_err", 32'(bus.pend_err), 32'h0);
    tick();

    // Underflow on r6 sets a sticky error.
    idle(); bus.write_en = 1; bus.write_addr = 6; bus.write_data = 32'h6; step();
    idle(); settle();
    check("underflow_err", 32'(bus.pend_err), 32'h1);
    tick();
    idle(); step(); settle();
    check("err_sticky", 32'(bus.pend_err), 32'h1);
    tick();

    // Overflow on r8 saturates at 3.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); bus.reserve_en = 1; bus.reserve_addr = 8; step();
    end
    idle(); settle();
    check("r8_no_err_at_3", 32'(bus.pend_err), 32'h0);
    tick();
    idle(); bus.reserve_en = 1; bus.reserve_addr = 8; step();
    idle(); bus.read_en_1 = 1; bus.read_addr_1 = 8; settle();
    check("overflow_err", 32'(bus.pend_err), 32'h1);
    check("r8_busy", 32'(bus.read_busy_1), 32'h1);
    tick();
    for (int i = 0; i < 2; i++) begin
      idle(); bus.write_en = 1; bus.write_addr = 8; bus.write_data = 32'(i); step();
    end
    idle(); bus.read_en_1 = 1; bus.read_addr_1 = 8; settle();
    check("r8_one_left", 32'(bus.read_busy_1), 32'h1);
    tick();
    do_reset();
    idle(); bus.read_en_1 = 1; bus.read_addr_1 = 8; settle();
    check("rst_clears_err", 32'(bus.pend_err), 32'h0);
    check("rst_clears_busy", 32'(bus.read_busy_1), 32'h0);
    tick();

    // Random traffic concentrated on a few registers to exercise collisions.
    for (int i = 0; i < 500; i++) begin
      rst              = ($urandom_range(0, 59) == 0);
      bus.read_en_1    = ($urandom_range(0, 3) != 0);
      bus.read_addr_1  = 5'($urandom_range(0, 7));
      bus.read_en_2    = ($urandom_range(0, 3) != 0);
      bus.read_addr_2  = 5'($urandom_range(0, 7));
      bus.write_en     = ($urandom_range(0, 2) == 0);
      bus.write_addr   = 5'($urandom_range(0, 7));
      bus.write_data   = $urandom;
      bus.reserve_en   = ($urandom_range(0, 2) == 0);
      bus.reserve_addr = 5'($urandom_range(0, 7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
